// File: rtl/tag_ctrl_if.sv
// Bundles the request/response, tag-store and fill-side signals of tag_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface tag_ctrl_if #(
  parameter int TAG_W = 8,
  parameter int IDX_W = 2,
  parameter int WAYS  = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W+IDX_W-1:0] req_addr;
  logic                   resp_valid;
  logic                   resp_hit;
  logic [WAYS-1:0]        resp_way;
  logic                   ts_valid;
  logic                   ts_r;
  logic                   ts_w;
  logic [IDX_W-1:0]       ts_index;
  logic [WAYS-1:0]        ts_way;
  logic [TAG_W-1:0]       ts_tag;
  logic [WAYS-1:0]        ts_V;
  logic [WAYS-1:0]        ts_hit;
  logic [TAG_W-1:0]       ts_tag_out;
  logic                   fill_req;
  logic [TAG_W+IDX_W-1:0] fill_addr;
  logic [TAG_W-1:0]       fill_victim_tag;
  logic                   fill_victim_valid;
  logic                   fill_ack;

  modport slave (
    input  req_valid, req_addr, ts_hit, ts_tag_out, fill_ack,
    output req_ready, resp_valid, resp_hit, resp_way,
           ts_valid, ts_r, ts_w, ts_index, ts_way, ts_tag, ts_V,
           fill_req, fill_addr, fill_victim_tag, fill_victim_valid
  );

  modport master (
    output req_valid, req_addr, ts_hit, ts_tag_out, fill_ack,
    input  req_ready, resp_valid, resp_hit, resp_way,
           ts_valid, ts_r, ts_w, ts_index, ts_way, ts_tag, ts_V,
           fill_req, fill_addr, fill_victim_tag, fill_victim_valid
  );
endinterface

// File: rtl/tag_ctrl.sv
// Lookup/fill controller for the 4-set x 4-way tag store.
// Define TAGCTRL_PLRU_EN for tree pseudo-LRU replacement; otherwise round-robin.
//
// state  | meaning
// IDLE   | ready for a request, address latched on accept
// LOOKUP | tag store read, hit qualified with valid bits, victim chosen
// FILL   | waiting for fill_ack from the memory side
// WRITE  | new tag written into the victim way
// RESP   | one-cycle response pulse
module tag_ctrl #(
  parameter int TAG_W = 8,
  parameter int IDX_W = 2,
  parameter int WAYS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  tag_ctrl_if.slave  bus
);
  localparam int SETS = 1 << IDX_W;
  localparam int AW   = TAG_W + IDX_W;
  localparam int RR_W = $clog2(WAYS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    addr_q;
  logic [WAYS-1:0]  vb [SETS];
  logic [WAYS-1:0]  way_q;
  logic             hit_q;
  logic [TAG_W-1:0] vtag_q;
  logic             vvalid_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WAYS-1:0]  vb_set, qhit, hit_sel, invalid, victim, repl_way;

  assign idx     = addr_q[IDX_W-1:0];
  assign tag     = addr_q[AW-1:IDX_W];
  assign vb_set  = vb[idx];
  assign qhit    = bus.ts_hit & vb_set;
  assign hit_sel = qhit & (~qhit + WAYS'(1));
  assign invalid = ~vb_set;
  assign victim  = (|invalid) ? (invalid & (~invalid + WAYS'(1))) : repl_way;

`ifdef TAGCTRL_PLRU_EN
  // per set: [2]=root, [1]=b1, [0]=b2
  logic [2:0] plru [SETS];
  logic [2:0] plru_set;

  assign plru_set = plru[idx];
  assign repl_way = plru_set[2] ? (plru_set[0] ? 4'b1000 : 4'b0100)
                                : (plru_set[1] ? 4'b0010 : 4'b0001);

  function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [WAYS-1:0] w);
    logic [2:0] n;
    n = s;
    if (w[0] | w[1]) begin
      n[2] = 1'b1;
      n[1] = w[0];
    end else begin
      n[2] = 1'b0;
      n[0] = w[2];
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) plru[i] <= '0;
    end else if (state == S_LOOKUP && |qhit) begin
      plru[idx] <= plru_touch(plru_set, hit_sel);
    end else if (state == S_WRITE) begin
      plru[idx] <= plru_touch(plru_set, way_q);
    end
  end
`else
  logic [RR_W-1:0] rr [SETS];

  assign repl_way = WAYS'(1) << rr[idx];

  // only advances when a fill evicts from a fully valid set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) rr[i] <= '0;
    end else if (state == S_WRITE && &vb_set) begin
      rr[idx] <= rr[idx] + RR_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      way_q    <= '0;
      hit_q    <= 1'b0;
      vtag_q   <= '0;
      vvalid_q <= 1'b0;
      for (int i = 0; i < SETS; i++) vb[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (bus.req_valid) addr_q <= bus.req_addr;
        S_LOOKUP: begin
          hit_q <= |qhit;
          if (|qhit) begin
            way_q <= hit_sel;
          end else begin
            way_q    <= victim;
            vtag_q   <= bus.ts_tag_out;
            vvalid_q <= &vb_set;
          end
        end
        S_WRITE: vb[idx] <= vb_set | way_q;
        default: ;
      endcase
    end
  end

  // outputs are forced low for as long as rst is held
  always_comb begin
    state_nx              = state;
    bus.req_ready         = 1'b0;
    bus.resp_valid        = 1'b0;
    bus.resp_hit          = 1'b0;
    bus.resp_way          = '0;
    bus.ts_valid          = 1'b0;
    bus.ts_r              = 1'b0;
    bus.ts_w              = 1'b0;
    bus.ts_index          = '0;
    bus.ts_way            = '0;
    bus.ts_tag            = '0;
    bus.ts_V              = '0;
    bus.fill_req          = 1'b0;
    bus.fill_addr         = '0;
    bus.fill_victim_tag   = '0;
    bus.fill_victim_valid = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) state_nx = S_LOOKUP;
        end
        S_LOOKUP: begin
          bus.ts_valid = 1'b1;
          bus.ts_r     = 1'b1;
          bus.ts_index = idx;
          bus.ts_tag   = tag;
          bus.ts_V     = vb_set;
          bus.ts_way   = victim;
          state_nx     = (|qhit) ? S_RESP : S_FILL;
        end
        S_FILL: begin
          bus.fill_req          = 1'b1;
          bus.fill_addr         = addr_q;
          bus.fill_victim_tag   = vtag_q;
          bus.fill_victim_valid = vvalid_q;
          if (bus.fill_ack) state_nx = S_WRITE;
        end
        S_WRITE: begin
          bus.ts_valid = 1'b1;
          bus.ts_w     = 1'b1;
          bus.ts_index = idx;
          bus.ts_way   = way_q;
          bus.ts_tag   = tag;
          bus.ts_V     = vb_set;
          state_nx     = S_RESP;
        end
        S_RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_hit   = hit_q;
          bus.resp_way   = way_q;
          state_nx       = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_ctrl.sv
// Self-checking bench for tag_ctrl: directed scenarios plus random traffic
// against a per-set way/valid/tag model with the replacement rules applied directly.
module tb_tag_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_ctrl_if bus();
  tag_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // tag store: combinational read, write on ts_w
  logic [7:0] ts_mem [4][4] = '{default: '0};
  logic [3:0] hitv;
  logic [7:0] tout;
  always_comb begin
    hitv = '0;
    tout = '0;
    for (int w = 0; w < 4; w++) begin
      hitv[w] = (ts_mem[bus.ts_index][w] == bus.ts_tag);
      if (bus.ts_way[w]) tout = ts_mem[bus.ts_index][w];
    end
  end
  assign bus.ts_hit     = hitv;
  assign bus.ts_tag_out = tout;
  always @(posedge clk)
    if (bus.ts_w)
      for (int w = 0; w < 4; w++)
        if (bus.ts_way[w]) ts_mem[bus.ts_index][w] <= bus.ts_tag;

  int accepts = 0;
  always @(posedge clk) if (bus.req_valid && bus.req_ready) accepts++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // reference model
  logic [7:0] m_tag [4][4] = '{default: '0};
  bit         m_v   [4][4];
  bit         m_root [4];
  bit         m_b1   [4];
  bit         m_b2   [4];
  int         m_rr   [4];

  function automatic logic [3:0] oh(input int k);
    return 4'(1 << k);
  endfunction

  function automatic logic [3:0] m_vbits(input int s);
    return {m_v[s][3], m_v[s][2], m_v[s][1], m_v[s][0]};
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) m_v[s][w] = 0;
      m_root[s] = 0; m_b1[s] = 0; m_b2[s] = 0; m_rr[s] = 0;
    end
  endtask

  function automatic int m_victim(input int s);
    for (int w = 0; w < 4; w++) if (!m_v[s][w]) return w;
`ifdef TAGCTRL_PLRU_EN
    if (m_root[s]) return m_b2[s] ? 3 : 2;
    return m_b1[s] ? 1 : 0;
`else
    return m_rr[s];
`endif
  endfunction

  task automatic m_touch(input int s, input int k);
`ifdef TAGCTRL_PLRU_EN
    m_root[s] = (k < 2);
    if (k < 2) m_b1[s] = (k == 0);
    else       m_b2[s] = (k == 2);
`endif
  endtask

  task automatic m_fill(input int s, input int k, input logic [7:0] t);
    bit full;
    full = m_v[s][0] && m_v[s][1] && m_v[s][2] && m_v[s][3];
`ifndef TAGCTRL_PLRU_EN
    if (full) m_rr[s] = (m_rr[s] + 1) % 4;
`endif
    m_v[s][k]   = 1;
    m_tag[s][k] = t;
    m_touch(s, k);
  endtask

  task automatic do_req(input logic [9:0] addr, input int ack_dly, input bit hold,
                        output logic [3:0] o_way, output logic [7:0] o_vtag);
    int s;
    int hw;
    int vic;
    int n;
    logic [7:0] t;
    s = int'(addr[1:0]);
    t = addr[9:2];
    hw = -1;
    o_vtag = '0;
    for (int w = 3; w >= 0; w--) if (m_v[s][w] && m_tag[s][w] == t) hw = w;
    vic = m_victim(s);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    chk("lk_ts_valid", bus.ts_valid, 1);
    chk("lk_ts_r", bus.ts_r, 1);
    chk("lk_ts_w", bus.ts_w, 0);
    chk("lk_ts_index", bus.ts_index, s);
    chk("lk_ts_tag", bus.ts_tag, t);
    chk("lk_ts_way", bus.ts_way, oh(vic));
    chk("lk_ts_V", bus.ts_V, m_vbits(s));
    chk("lk_req_ready", bus.req_ready, 0);
    @(negedge clk);
    if (hw >= 0) begin
      chk("hit_resp_valid", bus.resp_valid, 1);
      chk("hit_resp_hit", bus.resp_hit, 1);
      chk("hit_resp_way", bus.resp_way, oh(hw));
      chk("hit_fill_req", bus.fill_req, 0);
      chk("hit_ts_valid", bus.ts_valid, 0);
      o_way = bus.resp_way;
      m_touch(s, hw);
    end else begin
      chk("fill_req", bus.fill_req, 1);
      chk("fill_addr", bus.fill_addr, addr);
      chk("fill_victim_valid", bus.fill_victim_valid, m_v[s][vic]);
      chk("fill_victim_tag", bus.fill_victim_tag, m_tag[s][vic]);
      chk("fill_ts_valid", bus.ts_valid, 0);
      o_vtag = bus.fill_victim_tag;
      repeat (ack_dly) begin
        @(negedge clk);
        chk("fill_req_hold", bus.fill_req, 1);
        chk("fill_addr_hold", bus.fill_addr, addr);
        chk("fill_req_ready", bus.req_ready, 0);
      end
      bus.fill_ack = 1'b1;
      @(negedge clk);
      bus.fill_ack = 1'b0;
      chk("wr_ts_valid", bus.ts_valid, 1);
      chk("wr_ts_w", bus.ts_w, 1);
      chk("wr_ts_r", bus.ts_r, 0);
      chk("wr_ts_way", bus.ts_way, oh(vic));
      chk("wr_ts_tag", bus.ts_tag, t);
      chk("wr_ts_index", bus.ts_index, s);
      chk("wr_fill_req", bus.fill_req, 0);
      m_fill(s, vic, t);
      @(negedge clk);
      chk("miss_resp_valid", bus.resp_valid, 1);
      chk("miss_resp_hit", bus.resp_hit, 0);
      chk("miss_resp_way", bus.resp_way, oh(vic));
      o_way = bus.resp_way;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", bus.resp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  logic [3:0] ow;
  logic [7:0] ovt;
  int a0;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.fill_ack  = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_ts_valid", bus.ts_valid, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_req_ready", bus.req_ready, 1);

    do_req(10'h284, 3, 0, ow, ovt);
    chk("first_miss_way", ow, 4'b0001);
    do_req(10'h284, 0, 0, ow, ovt);
    chk("repeat_hit_way", ow, 4'b0001);
    do_req(10'h288, 0, 0, ow, ovt);
    do_req(10'h28C, 1, 0, ow, ovt);
    do_req(10'h290, 2, 0, ow, ovt);
    chk("a4_way", ow, 4'b1000);
    do_req(10'h284, 0, 0, ow, ovt);
    do_req(10'h294, 0, 0, ow, ovt);
`ifdef TAGCTRL_PLRU_EN
    chk("a5_victim_way", ow, 4'b0100);
    chk("a5_victim_tag", ovt, 8'hA3);
`else
    chk("a5_victim_way", ow, 4'b0001);
    chk("a5_victim_tag", ovt, 8'hA1);
`endif

    // reset in the middle of a fill
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h2A8;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_fill_req", bus.fill_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_hi_fill_req", bus.fill_req, 0);
    chk("rst_hi_req_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("rst_next_fill_req", bus.fill_req, 0);
    rst = 1'b0;
    #1;
    chk("rst_fall_req_ready", bus.req_ready, 1);
    chk("rst_fall_fill_req", bus.fill_req, 0);
    m_clear();

    do_req(10'h284, 1, 0, ow, ovt);
    chk("post_rst_way", ow, 4'b0001);
    do_req(10'h285, 0, 0, ow, ovt);
    do_req(10'h284, 0, 0, ow, ovt);
    chk("set0_kept_way", ow, 4'b0001);

    a0 = accepts;
    do_req(10'h2B6, 2, 1, ow, ovt);
    chk("hold_accepts", accepts - a0, 1);

    @(negedge clk);
    bus.fill_ack = 1'b1;
    @(negedge clk);
    bus.fill_ack = 1'b0;
    chk("idle_ack_ready", bus.req_ready, 1);
    chk("idle_ack_fill_req", bus.fill_req, 0);
    chk("idle_ack_ts_valid", bus.ts_valid, 0);
    do_req(10'h2B6, 0, 0, ow, ovt);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] rt;
      logic [1:0] ri;
      rt = 8'hB0 + 8'($urandom_range(0, 5));
      ri = 2'($urandom_range(0, 3));
      do_req({rt, ri}, int'($urandom_range(0, 3)), 0, ow, ovt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tag_ctrl.md
# tag_ctrl

Lookup/fill controller that initiates every access to the 4-set × 4-way `tagStore` in the M-stage cache. It accepts one address request at a time and drives the tag store's read/write port. It qualifies the returned hit vector with its own valid bits and picks a victim on a miss. It then runs a fill handshake with the memory side and writes the new tag into the victim way.

## Interface
- `TAG_W`, 8, tag width
- `IDX_W`, 2, index width (4 sets)
- `WAYS`, 4, associativity; one-hot way encoding

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (IDLE only)
- `req_addr`  in  TAG_W+IDX_W  `{tag, index}`; index = low IDX_W bits
- `resp_valid`  out  1  one-cycle response pulse
- `resp_hit`  out  1  1 = hit, 0 = serviced miss
- `resp_way`  out  WAYS  one-hot way now holding the tag
- `ts_valid`, `ts_r`, `ts_w`  out  1 each  tag store strobes
- `ts_index`  out  IDX_W  set index
- `ts_way`  out  WAYS  one-hot way select
- `ts_tag`  out  TAG_W  tag to compare/write
- `ts_V`  out  WAYS  valid bits of the indexed set
- `ts_hit`  in  WAYS  raw compare vector from tag store
- `ts_tag_out`  in  TAG_W  stored tag of the `ts_way` way
- `fill_req`  out  1  miss fill request, level
- `fill_addr`  out  TAG_W+IDX_W  missed address
- `fill_victim_tag`  out  TAG_W  tag being evicted
- `fill_victim_valid`  out  1  victim held a valid tag
- `fill_ack`  in  1  fill complete

## Operation
- State: valid array `vb[4][4]`, replacement state per set, latched address, latched victim.
- FSM: IDLE → LOOKUP → (hit) RESP → IDLE; (miss) FILL → WRITE → RESP → IDLE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch `req_addr` and go to LOOKUP.
- LOOKUP:
  - Outputs: `ts_valid=1`, `ts_r=1`, `ts_index`/`ts_tag` from the latched address, `ts_V=vb[index]`, `ts_way`=victim candidate.
  - Qualified hit = `ts_hit & vb[index]`. If multiple bits are set, the lowest set bit wins.
  - On a hit: record the hit way and update the replacement state.
  - On a miss: latch the victim, and `ts_tag_out` as `fill_victim_tag`.
  - Victim = lowest-numbered invalid way, else the replacement choice.
- FILL:
  - `fill_req=1` with `fill_addr`, `fill_victim_tag` and `fill_victim_valid` held stable.
  - Exit to WRITE on the edge where `fill_ack=1`. An ack in the first FILL cycle is accepted.
  - `fill_ack` in any other state is ignored.
- WRITE:
  - Outputs: `ts_valid=1`, `ts_w=1`, `ts_way`=victim, `ts_tag`=latched tag.
  - Set `vb[index][victim]` and update the replacement state.
- RESP: `resp_valid=1`, `resp_hit`, `resp_way` valid for exactly this cycle.

## Timing
- Request accepted at edge N: LOOKUP in cycle N+1.
- Hit: `resp_valid` in cycle N+2.
- Miss: `fill_req` rises in cycle N+2. If `fill_ack` is sampled at the end of cycle K, WRITE is cycle K+1 and RESP is cycle K+2.
- Throughput: one request in flight; `req_ready=0` from LOOKUP through RESP.
- `rst` (any state, including mid-FILL):
  - Next cycle is IDLE.
  - All `vb` and replacement state cleared.
  - Every output 0 while `rst` is high.
  - `req_ready=1` in the first cycle after `rst` falls.
- All `ts_*` strobes are 0 outside LOOKUP/WRITE.

## Configuration
- `TAGCTRL_PLRU_EN` defined: 3-bit tree pseudo-LRU per set.
  - Bits: `root`, `b1`, `b2`.
  - Victim = `root ? (b2 ? 3 : 2) : (b1 ? 1 : 0)`.
  - Touch way k: `root = (k<2)`; if k<2, `b1 = (k==0)`, else `b2 = (k==2)`.
  - Touched on every hit and fill. Reset is all 0.
- Undefined: 2-bit round-robin counter per set.
  - Victim = counter.
  - Counter increments only on fills into a fully valid set.

## Test plan
- Reset, then request 0x284 (tag A1, idx 0):
  - `ts_way=0001`; `fill_req` with `fill_addr=0x284` and `fill_victim_valid=0`.
  - Ack after 3 cycles → `ts_w` pulse (way 0001, tag A1).
  - RESP with `resp_hit=0`, `resp_way=0001`.
- Repeat 0x284 → `resp_valid` with `resp_hit=1`, `resp_way=0001` two cycles after accept; no `fill_req`.
- Fill idx 0 with tags A1–A4 (ways 0–3), hit A1, then request tag A5:
  - PLRU: victim way 0100, `fill_victim_tag=A3`, `fill_victim_valid=1`.
  - Without macro: victim way 0001, `fill_victim_tag=A1`.
- Assert `rst` mid-FILL:
  - `fill_req=0` in the next cycle.
  - A subsequent 0x284 misses with `fill_victim_valid=0`.
- After filling 0x284, request 0x285 (idx 1) → miss; set 0 contents are unaffected.
- Hold `req_valid` during a miss → `req_ready=0`, only one accept. `fill_ack` pulsed in IDLE → no state change.
